// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage with PC, direct-mapped one-word-per-line I-cache and memory refill FSM.
// Ports:
//   clk_in, rst_in (async, active-high)       clock and reset
//   stall                                      chip stall, holds PC and FSM
//   branch_taken, branch_target                one-cycle redirect from EX
//   mem_req, mem_addr, mem_ready, mem_rdata    word fetch handshake to the memory controller
//   if_pc, if_ins                              PC/instruction to IF/ID (0 / NOP_INS on bubbles)
//   if_stall_req                               asserted while no instruction is available
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h00000000,
    parameter int          ICACHE_LINES = 64,
    parameter logic [31:0] NOP_INS      = 32'h00000013
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_ins,
    output logic        if_stall_req
);
    localparam int IDX = $clog2(ICACHE_LINES);
    localparam int TW  = 30 - IDX;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                  r_state;
    logic [31:0]             r_pc;
    logic [31:0]             r_mem_addr;
    logic                    r_mem_req;
    logic [ICACHE_LINES-1:0] r_valid;
    logic [TW-1:0]           r_tag  [ICACHE_LINES];
    logic [31:0]             r_data [ICACHE_LINES];

    logic [IDX-1:0] w_idx;
    logic [IDX-1:0] w_fidx;
    logic           w_hit;
    logic           w_fill;
    logic [31:0]    w_target;

    assign w_idx    = r_pc[IDX+1:2];
    assign w_fidx   = r_mem_addr[IDX+1:2];
    assign w_hit    = r_state == IDLE && r_valid[w_idx] && r_tag[w_idx] == r_pc[31:IDX+2];
    // The refill completes even when stalled or redirected: the data is correct for mem_addr.
    assign w_fill   = r_state == WAIT_MEM && mem_ready;
    assign w_target = branch_target & 32'hFFFF_FFFC;

    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    // A redirect cycle is always a bubble but must not ask the stall controller to freeze EX.
    assign if_pc        = w_hit && !branch_taken ? r_pc : 32'd0;
    assign if_ins       = w_hit && !branch_taken ? r_data[w_idx] : NOP_INS;
    assign if_stall_req = !branch_taken && !w_hit;

    // Tag and data arrays need no reset; the valid bits gate them.
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= r_mem_addr[31:IDX+2];
            r_data[w_fidx] <= mem_rdata;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_valid    <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'd0;
        end else if (r_state == IDLE) begin
            if (branch_taken) begin
                r_pc <= w_target;
            end else if (!stall) begin
                if (w_hit) begin
                    r_pc <= r_pc + 32'd4;
                end else begin
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= {r_pc[31:2], 2'b00};
                    r_state    <= WAIT_MEM;
                end
            end
        end else begin
            // The in-flight request is never cancelled; a redirect only moves the PC,
            // and the next IDLE cycle re-evaluates hit against the new PC.
            if (branch_taken)
                r_pc <= w_target;
            if (mem_ready) begin
                r_valid[w_fidx] <= 1'b1;
                r_mem_req       <= 1'b0;
                r_state         <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed bench for if_fetch_unit against an address-level fetch model.
module tb_if_fetch_unit;
    localparam int          L   = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_in = 1'b0;
    logic        rst_in, stall, branch_taken, mem_ready, mem_req, if_stall_req;
    logic [31:0] branch_target, mem_addr, mem_rdata, if_pc, if_ins;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 3;
    int cnt     = 0;
    bit spur    = 0;

    // Model: PC, outstanding request, and cache contents as "which word address sits at each index".
    logic [31:0] m_pc, m_addr;
    bit          m_busy;
    logic [31:0] c_addr [int];
    logic [31:0] e_pc, e_ins;
    logic        e_stall;
    bit          e_hit;

    if_fetch_unit #(.RESET_PC(32'h0), .ICACHE_LINES(L), .NOP_INS(NOP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .if_pc(if_pc), .if_ins(if_ins),
        .if_stall_req(if_stall_req)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'd0 ? 32'h00100093 : {~a[15:0], a[17:2]};
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 2) % L);
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_busy = 0; m_addr = 32'd0; cnt = 0;
        c_addr.delete();
    endtask

    // Called at posedge+1 after inputs are set: drive memory response, compute expectations, move to negedge.
    task automatic prep();
        cnt       = mem_req ? cnt + 1 : 0;
        mem_ready = (mem_req && cnt >= lat) || spur;
        mem_rdata = spur ? 32'hDEADBEEF : mem_ready ? mem_word(mem_addr) : $urandom;
        e_hit     = !m_busy && c_addr.exists(idx(m_pc)) && c_addr[idx(m_pc)] == m_pc;
        e_pc      = e_hit && !branch_taken ? m_pc : 32'd0;
        e_ins     = e_hit && !branch_taken ? mem_word(m_pc) : NOP;
        e_stall   = !branch_taken && !e_hit;
        #4;
    endtask

    task automatic adv();
        @(posedge clk_in);
        if (!m_busy) begin
            if (branch_taken) m_pc = branch_target & ~32'd3;
            else if (!stall) begin
                if (e_hit) m_pc = m_pc + 32'd4;
                else begin m_busy = 1; m_addr = m_pc; end
            end
        end else begin
            if (mem_ready) begin c_addr[idx(m_addr)] = m_addr; m_busy = 0; end
            if (branch_taken) m_pc = branch_target & ~32'd3;
        end
        #1;
    endtask

    task automatic settle();
        stall = 0; branch_taken = 0;
        for (int k = 0; k < 20 && m_busy; k++) begin prep(); adv(); end
    endtask

    task automatic test_reset();
        rst_in = 1; stall = 0; branch_taken = 0; branch_target = 0; mem_ready = 0; mem_rdata = 0;
        #1;
        n_tests++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0 || if_pc !== 32'd0 || if_ins !== NOP || if_stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: req=%b addr=%h pc=%h ins=%h sr=%b, expected 0 00000000 00000000 %h 1", mem_req, mem_addr, if_pc, if_ins, if_stall_req, NOP);
        end
        @(posedge clk_in); #1;
        rst_in = 0; model_reset(); lat = 3;
        for (int i = 0; i < 6; i++) begin
            prep(); n_tests++;
            if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                n_fail++;
                $display("FAIL reset_seq[%0d]: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", i, if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
            end
            if (i == 4) begin
                n_tests++;
                if (if_pc !== 32'd0 || if_ins !== 32'h00100093 || if_stall_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL first_ins: got pc=%h ins=%h sr=%b, expected 00000000 00100093 0", if_pc, if_ins, if_stall_req);
                end
            end
            adv();
        end
    endtask

    task automatic test_loop();
        int k = 0;
        lat = 2;
        while (!(m_pc == 32'd12 && !m_busy) && k < 40) begin
            prep(); n_tests++;
            if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                n_fail++;
                $display("FAIL preload: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
            end
            adv(); k++;
        end
        n_tests++;
        if (k >= 40) begin n_fail++; $display("FAIL preload_timeout: cycles=%0d, expected < 40", k); end
        branch_taken = 1; branch_target = 32'd0;
        prep(); adv();
        branch_taken = 0;
        for (int i = 0; i < 3; i++) begin
            prep(); n_tests++;
            if (if_pc !== 32'(4 * i) || if_ins !== mem_word(32'(4 * i)) || if_stall_req !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL loop_hit[%0d]: got pc=%h ins=%h sr=%b req=%b, expected pc=%h ins=%h sr=0 req=0", i, if_pc, if_ins, if_stall_req, mem_req, 32'(4 * i), mem_word(32'(4 * i)));
            end
            adv();
        end
    endtask

    task automatic test_stall();
        settle();
        for (int j = 0; j < 7; j++) begin
            branch_taken = j == 0; branch_target = 32'd0;
            stall = j == 3 || j == 4;
            prep(); n_tests++;
            if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                n_fail++;
                $display("FAIL stall[%0d]: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", j, if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
            end
            if (j >= 3 && j <= 5) begin
                n_tests++;
                if (if_pc !== 32'd8 || if_stall_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d]: got pc=%h sr=%b, expected 00000008 0", j, if_pc, if_stall_req);
                end
            end
            adv();
        end
        stall = 0;
    endtask

    task automatic test_branch_wait();
        int k = 0;
        settle(); lat = 5;
        for (int j = 0; j < 9; j++) begin
            branch_taken = j == 0 || j == 4;
            branch_target = j == 0 ? 32'h40 : 32'h100;
            prep(); n_tests++;
            if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                n_fail++;
                $display("FAIL br_wait[%0d]: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", j, if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
            end
            if ((j >= 2 && j <= 6 && (mem_req !== 1'b1 || mem_addr !== 32'h40)) || (j == 8 && (mem_req !== 1'b1 || mem_addr !== 32'h100))) begin
                n_fail++;
                $display("FAIL br_wait_addr[%0d]: got req=%b addr=%h, expected req=1 addr=%h", j, mem_req, mem_addr, j == 8 ? 32'h100 : 32'h40);
            end
            if ((j >= 2 && j <= 6) || j == 8) n_tests++;
            adv();
        end
        branch_taken = 0;
        while (m_busy && k < 20) begin prep(); adv(); k++; end
        branch_taken = 1; branch_target = 32'h40;
        prep(); adv();
        branch_taken = 0;
        prep(); n_tests++;
        if (if_pc !== 32'h40 || if_ins !== mem_word(32'h40) || if_stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL br_wait_filled: got pc=%h ins=%h sr=%b, expected 00000040 %h 0", if_pc, if_ins, if_stall_req, mem_word(32'h40));
        end
        adv();
    endtask

    task automatic test_branch_stall();
        settle(); lat = 2;
        for (int j = 0; j < 4; j++) begin
            stall = j < 2; branch_taken = j == 0; branch_target = 32'h203;
            prep(); n_tests++;
            if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                n_fail++;
                $display("FAIL br_stall[%0d]: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", j, if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
            end
            if (j == 0) begin
                n_tests++;
                if (if_pc !== 32'd0 || if_ins !== NOP || if_stall_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL br_stall_bubble: got pc=%h ins=%h sr=%b, expected 00000000 %h 0", if_pc, if_ins, if_stall_req, NOP);
                end
            end
            if (j == 3) begin
                n_tests++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
                    n_fail++;
                    $display("FAIL br_stall_pc: got req=%b addr=%h, expected req=1 addr=00000200", mem_req, mem_addr);
                end
            end
            adv();
        end
        stall = 0; branch_taken = 0;
    endtask

    task automatic test_alias();
        logic [31:0] tg [3] = '{32'h0, 32'h100, 32'h0};
        settle(); lat = 2;
        for (int t = 0; t < 3; t++) begin
            branch_taken = 1; branch_target = tg[t];
            prep(); adv();
            branch_taken = 0;
            for (int c = 0; c < 4; c++) begin
                prep(); n_tests++;
                if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                    n_fail++;
                    $display("FAIL alias[%0d.%0d]: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", t, c, if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
                end
                if (c == 0) begin
                    n_tests++;
                    if (if_stall_req !== 1'b1) begin n_fail++; $display("FAIL alias_miss[%0d]: got sr=%b, expected 1", t, if_stall_req); end
                end
                if (c == 3) begin
                    n_tests++;
                    if (if_pc !== tg[t] || if_stall_req !== 1'b0) begin
                        n_fail++;
                        $display("FAIL alias_hit[%0d]: got pc=%h sr=%b, expected %h 0", t, if_pc, if_stall_req, tg[t]);
                    end
                end
                adv();
            end
        end
    endtask

    task automatic test_reset_mid();
        settle(); lat = 4;
        branch_taken = 1; branch_target = 32'h300;
        prep(); adv();
        branch_taken = 0;
        prep(); adv();
        prep(); adv();
        rst_in = 1; #1;
        n_tests++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0 || if_stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got req=%b addr=%h sr=%b, expected 0 00000000 1", mem_req, mem_addr, if_stall_req);
        end
        @(posedge clk_in); #1;
        rst_in = 0; model_reset(); spur = 1;
        for (int j = 0; j < 8; j++) begin
            prep(); spur = 0; n_tests++;
            if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                n_fail++;
                $display("FAIL reset_mid_seq[%0d]: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", j, if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
            end
            adv();
        end
    endtask

    task automatic test_wrap();
        bit seen_fc = 0, seen_wrap = 0;
        settle(); lat = 1;
        branch_taken = 1; branch_target = 32'hFFFF_FFF8;
        prep(); adv();
        branch_taken = 0;
        for (int j = 0; j < 14; j++) begin
            prep(); n_tests++;
            if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", j, if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
            end
            if (seen_fc && if_stall_req === 1'b0 && if_pc === 32'd0) seen_wrap = 1;
            if (if_stall_req === 1'b0 && if_pc === 32'hFFFF_FFFC) seen_fc = 1;
            adv();
        end
        n_tests++;
        if (!seen_wrap) begin n_fail++; $display("FAIL wrap_seq: got fc=%0d wrap=%0d, expected fc=1 wrap=1", seen_fc, seen_wrap); end
    endtask

    task automatic test_random();
        for (int j = 0; j < 1500; j++) begin
            if (!mem_req) lat = 1 + int'($urandom_range(3));
            stall         = $urandom_range(3) == 0;
            branch_taken  = $urandom_range(7) == 0;
            branch_target = $urandom_range(15) == 0 ? $urandom : 32'($urandom_range(1023));
            prep(); n_tests++;
            if (if_pc !== e_pc || if_ins !== e_ins || if_stall_req !== e_stall || mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
                n_fail++;
                $display("FAIL random[%0d]: got pc=%h ins=%h sr=%b req=%b addr=%h, expected pc=%h ins=%h sr=%b req=%b addr=%h", j, if_pc, if_ins, if_stall_req, mem_req, mem_addr, e_pc, e_ins, e_stall, m_busy, m_addr);
            end
            adv();
        end
        stall = 0; branch_taken = 0;
    endtask

    initial begin
        test_reset();
        test_loop();
        test_stall();
        test_branch_wait();
        test_branch_stall();
        test_alias();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
